// File: rtl/line_codec_pkg.sv
// Shared constants, FSM state type and popcount helper for the line encoder/decoder family.
package line_codec_pkg;

  localparam int unsigned LINES      = 8;
  localparam int unsigned CODE_WIDTH = 3;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  function automatic logic [3:0] popcount(input logic [LINES-1:0] vec);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      n = n + {3'b000, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/priority_encoder_8to3.sv
// Combinational priority encoder: index of the highest set bit plus an any-set flag.
module priority_encoder_8to3
  import line_codec_pkg::*;
(
  input  logic [LINES-1:0]      vec,
  output logic [CODE_WIDTH-1:0] index,
  output logic                  any
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (vec[i]) begin
        index = CODE_WIDTH'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_encoder_serializer.sv
// Captures a multi-hot line vector and drains it as 3-bit codes, highest line first,
// one code per Valid/Ready handshake.
module line_encoder_serializer #(
  parameter int unsigned LINES      = 8,
  parameter int unsigned CODE_WIDTH = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Load,
  input  logic [LINES-1:0]      Lines_In,
  output logic                  Busy,
  output logic                  Valid,
  input  logic                  Ready,
  output logic [CODE_WIDTH-1:0] Code,
  output logic                  Last,
  output logic [3:0]            Remaining,
  output logic                  Zero,
  output logic                  Overrun
);

  import line_codec_pkg::*;

  state_t                  state, state_next;
  logic [LINES-1:0]        pending, pending_next;
  logic                    zero_q, zero_next;
  logic                    overrun_q, overrun_next;
  logic [CODE_WIDTH-1:0]   top_index;
  logic                    top_any;
  logic [3:0]              count;

  priority_encoder_8to3 u_encoder (
    .vec   (pending),
    .index (top_index),
    .any   (top_any)
  );

  assign count = popcount(pending);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      pending   <= '0;
      zero_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      zero_q    <= zero_next;
      overrun_q <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    zero_next    = 1'b0;
    overrun_next = overrun_q;
    Busy         = 1'b0;
    Valid        = 1'b0;

    case (state)
      IDLE: begin
        if (Enable && Load) begin
          if (|Lines_In) begin
            pending_next = Lines_In;
            state_next   = EMIT;
          end else begin
            zero_next = 1'b1;
          end
        end
      end
      EMIT: begin
        Busy  = 1'b1;
        Valid = 1'b1;
        if (Enable && Load) begin
          overrun_next = 1'b1;
        end
        // Clearing the reported bit empties pending on the last handshake.
        if (Ready) begin
          pending_next = pending & ~(LINES'(1) << top_index);
          if (count == 4'd1) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    Code      = (Valid && top_any) ? top_index : '0;
    Last      = Valid && (count == 4'd1);
    Remaining = count;
  end

  assign Zero    = zero_q;
  assign Overrun = overrun_q;

endmodule

// File: doc/line_encoder_serializer.md
# line_encoder_serializer

Captures an 8-bit line vector (the decoded form used by the team's 3-to-8 line decoders) and re-encodes it into 3-bit binary codes. It emits one code per handshake, highest-numbered active line first, until every set line has been reported. It sits upstream of a `Line_Decoder` stage or on any multi-hot status bus that must be drained into a narrow binary channel. Multi-hot inputs are serialized, not merely priority-resolved.

## Interface
- `LINES`, default 8: number of input lines; fixed at 8 for this revision.
- `CODE_WIDTH`, default 3: code width; equals log2(`LINES`).

Ports:
- `Clock`, input, 1: single clock, rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `Enable`, input, 1: gates acceptance of `Load`; has no effect on draining.
- `Load`, input, 1: request to capture `Lines_In`.
- `Lines_In`, input, 8: line vector; bit i corresponds to code i.
- `Busy`, output, 1: block holds pending lines; a `Load` is not accepted.
- `Valid`, output, 1: `Code` is presented.
- `Ready`, input, 1: downstream accepts `Code`.
- `Code`, output, 3: binary index of the highest pending line.
- `Last`, output, 1: the presented code is the final pending line.
- `Remaining`, output, 4: population count of the pending register (0–8).
- `Zero`, output, 1: one-cycle pulse when an accepted load had no set lines.
- `Overrun`, output, 1: sticky flag; a `Load` was dropped while `Busy`.

## Operation
- Internal state: 8-bit `Pending` register; two-state FSM with states IDLE and EMIT.
- **IDLE.** `Busy`=0, `Valid`=0.
  - `Enable`=1, `Load`=1, `Lines_In`≠0: `Pending`←`Lines_In`; go to EMIT.
  - `Enable`=1, `Load`=1, `Lines_In`=0: stay in IDLE; pulse `Zero` for one cycle.
  - `Enable`=0: `Load` is ignored silently; `Overrun` does not set.
- **EMIT.** `Busy`=1, `Valid`=1.
  - `Code` = index of the highest set bit of `Pending` (bit 7 has top priority).
  - `Last` = 1 when popcount(`Pending`)=1.
  - `Remaining` = popcount(`Pending`).
  - On `Valid`&`Ready`: clear the bit at `Code` in `Pending`.
  - If that handshake had `Last`=1: go to IDLE.
- `Load` with `Enable`=1 while in EMIT: input is dropped, `Pending` is untouched, `Overrun`←1. `Overrun` clears only on `Reset`.
- `Code`, `Last` and `Remaining` are pure functions of `Pending`; no combinational path from any input.
- `Code` is 0 whenever `Valid`=0.
- Reset values: `Pending`=0, FSM=IDLE, `Busy`=0, `Valid`=0, `Code`=0, `Last`=0, `Remaining`=0, `Zero`=0, `Overrun`=0.

## Timing
- Load latency: a load accepted at edge k gives `Valid`=1 with the first code after edge k.
- Throughput: one code per cycle while `Ready`=1; n set lines drain in n cycles.
- Backpressure: while `Valid`=1 and `Ready`=0, `Code`, `Last` and `Remaining` are held stable.
- `Valid` never drops without a handshake, except on `Reset`.
- Last handshake at edge m:
  - `Busy`=0 and `Valid`=0 after edge m.
  - A `Load` sampled at edge m is refused, with `Overrun`. The earliest accepted `Load` is at edge m+1.
- `Zero` is high for exactly the cycle after the accepting edge.
- `Reset` asserted mid-EMIT: all outputs go to reset values immediately (asynchronously). Pending codes are discarded without being emitted.

## Structure
- Package `line_codec_pkg` holds:
  - constants `LINES`=8 and `CODE_WIDTH`=3;
  - the FSM state enum (IDLE, EMIT);
  - a popcount function shared with the decoder-side checkers.
- Sub-module `priority_encoder_8to3`: combinational; 8-bit vector in → 3-bit index of the highest set bit plus an `any` flag. It is instantiated once on `Pending`.

## Test plan
- Load `Lines_In`=8'b00100100 with `Ready`=1:
  - two handshakes, `Code`=5 then 2;
  - `Remaining`=2 then 1; `Last`=0 then 1;
  - `Busy`=0 on the following cycle.
- Load 8'hFF with `Ready` toggling 1,0,1,…: codes 7 down to 0 in order; each code held stable through its `Ready`=0 cycles; eight handshakes total.
- Load 8'h00: `Zero` pulses for one cycle; `Valid` stays 0; `Busy` stays 0.
- `Load` 8'h81 accepted, then `Load` 8'h10 on the next cycle: `Overrun`=1; codes emitted are 7 and 0 only.
- `Enable`=0 with `Load`=1 and `Lines_In`=8'h0F: nothing is captured; `Overrun` stays 0.
- `Reset` pulsed after the first handshake of 8'h0C: all outputs at reset values immediately. A subsequent load of 8'h02 emits only code 1.
